regfile_wr_arbiter: RTL and testbench



---
 rtl/regfile_pkg.sv | 14 +
 rtl/rr_pick.sv | 35 +++
 rtl/regfile_wr_arbiter.sv | 82 ++++++++
 tb/tb_regfile_wr_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write arbiter slice.
package regfile_pkg;

  localparam int REG_AW  = 3;
  localparam int REG_DW  = 16;
  localparam int RF_NREQ = 4;

  // The pointer starts at the last requester so that requester 0 is
  // searched first after reset.
  function automatic int ptr_reset(input int nreq);
    return nreq - 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate, priority-encode, un-rotate.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] elig,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   winner,
  output logic            valid
);

  logic [NREQ-1:0] rot;
  int              offset;
  int              pos;

  // Search starts at ptr+1; rotate so that index sits at bit 0, take the
  // lowest set bit, then map the offset back to a requester index.
  always_comb begin
    rot    = NREQ'({elig, elig} >> (int'(ptr) + 1));
    offset = 0;
    valid  = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        offset = j;
        valid  = 1'b1;
      end
    end
    pos = int'(ptr) + 1 + offset;
    if (pos >= NREQ) begin
      pos = pos - NREQ;
    end
    winner = PW'(pos);
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter driving the register file's single registered write port.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = RF_NREQ,
  parameter int AW   = REG_AW,
  parameter int DW   = REG_DW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic             hold,
  output logic [NREQ-1:0]  gnt,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [DW-1:0]    wr_data,
  output logic             busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   winner;
  logic            valid;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt_next;
  logic [AW-1:0]   addr_next;
  logic [DW-1:0]   data_next;

  // A requester granted last cycle sits out one arbitration so a req that
  // is still high on the grant edge cannot be granted twice.
  assign elig = req & ~gnt;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .elig   (elig),
    .ptr    (ptr),
    .winner (winner),
    .valid  (valid)
  );

  // Decode the winner into a one-hot grant and select its address and data.
  always_comb begin
    gnt_next  = '0;
    addr_next = '0;
    data_next = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == PW'(i)) begin
        gnt_next[i] = 1'b1;
        addr_next   = req_addr[i*AW +: AW];
        data_next   = req_data[i*DW +: DW];
      end
    end
  end

  // Output registers and pointer; address/data/pointer hold when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      ptr     <= PW'(ptr_reset(NREQ));
    end else if (!hold && valid) begin
      gnt     <= gnt_next;
      wr_en   <= 1'b1;
      wr_addr <= addr_next;
      wr_data <= data_next;
      ptr     <= winner;
    end else begin
      gnt     <= '0;
      wr_en   <= 1'b0;
    end
  end

  assign busy = (|req) | wr_en;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed scoreboard bench for regfile_wr_arbiter.
module tb_regfile_wr_arbiter;
  import regfile_pkg::*;

  typedef struct {
    logic        en;
    logic [3:0]  gnt;
    logic [2:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [11:0] req_addr;
  logic [63:0] req_data;
  logic        hold;
  logic [3:0]  gnt;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;

  logic [2:0]  addr_tab [4];
  logic [15:0] data_tab [4];
  logic [15:0] rf [8];
  exp_t        sb [$];
  int          compared;
  int          mismatched;

  regfile_wr_arbiter #(
    .NREQ (RF_NREQ),
    .AW   (REG_AW),
    .DW   (REG_DW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .hold     (hold),
    .gnt      (gnt),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pack the per-requester tables onto the flat request buses.
  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*3 +: 3]   = addr_tab[i];
      req_data[i*16 +: 16] = data_tab[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_write(input int idx, input logic [2:0] a, input logic [15:0] d);
    exp_t e;
    e.en   = 1'b1;
    e.gnt  = 4'(1 << idx);
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic push_idle();
    exp_t e;
    e.en   = 1'b0;
    e.gnt  = 4'b0000;
    e.addr = 3'd0;
    e.data = 16'h0000;
    sb.push_back(e);
  endtask

  // Advance n cycles, compare each cycle's registered outputs against the
  // scoreboard, mirror writes into a register-file model, and optionally
  // drop req for any requester that sees its grant.
  task automatic run_cycles(input int n, input bit auto_drop);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $error("[TB] FAIL sb_underflow: observed wr_en %0b with no expected entry", wr_en);
      end else begin
        e = sb.pop_front();
        check("wr_en", 32'(wr_en), 32'(e.en));
        check("gnt", 32'(gnt), 32'(e.gnt));
        if (e.en) begin
          check("wr_addr", 32'(wr_addr), 32'(e.addr));
          check("wr_data", 32'(wr_data), 32'(e.data));
        end
      end
      if (wr_en === 1'b1) rf[wr_addr] = wr_data;
      if (auto_drop) req = req & ~gnt;
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    req        = 4'b0000;
    hold       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr_tab[i] = 3'd0;
      data_tab[i] = 16'h0000;
    end
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_wr_en", 32'(wr_en), 32'h0);
    check("rst_wr_addr", 32'(wr_addr), 32'h0);
    check("rst_wr_data", 32'(wr_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;

    // All four requesting, dropped on grant: order 0,1,2,3.
    $display("[TB] all four requesters");
    addr_tab[0] = 3'd1; data_tab[0] = 16'hA001;
    addr_tab[1] = 3'd2; data_tab[1] = 16'hA002;
    addr_tab[2] = 3'd3; data_tab[2] = 16'hA003;
    addr_tab[3] = 3'd4; data_tab[3] = 16'hA004;
    req = 4'b1111;
    #1;
    check("busy_req", 32'(busy), 32'h1);
    push_write(0, 3'd1, 16'hA001);
    push_write(1, 3'd2, 16'hA002);
    push_write(2, 3'd3, 16'hA003);
    push_write(3, 3'd4, 16'hA004);
    push_idle();
    run_cycles(5, 1'b1);

    // Single requester holding req: one write every other cycle.
    $display("[TB] single requester");
    addr_tab[2] = 3'd5; data_tab[2] = 16'hBEEF;
    req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      push_write(2, 3'd5, 16'hBEEF);
      push_idle();
    end
    run_cycles(6, 1'b0);
    req = 4'b0000;
    push_idle();
    run_cycles(1, 1'b0);

    // Fairness: 0 and 3 held high alternate (pointer sits at 2 here).
    $display("[TB] fairness");
    addr_tab[0] = 3'd6; data_tab[0] = 16'h0A0A;
    addr_tab[3] = 3'd0; data_tab[3] = 16'h3333;
    req = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      push_write(3, 3'd0, 16'h3333);
      push_write(0, 3'd6, 16'h0A0A);
    end
    run_cycles(8, 1'b0);
    req = 4'b0000;
    push_idle();
    run_cycles(1, 1'b0);

    // Hold: no write while held, exactly one write after release.
    $display("[TB] hold");
    addr_tab[1] = 3'd2; data_tab[1] = 16'h5A5A;
    req  = 4'b0010;
    hold = 1'b1;
    push_idle();
    push_idle();
    push_idle();
    run_cycles(3, 1'b1);
    hold = 1'b0;
    push_write(1, 3'd2, 16'h5A5A);
    push_idle();
    push_idle();
    run_cycles(3, 1'b1);

    // Same-register collision: both writes, in grant order.
    $display("[TB] same-register collision");
    addr_tab[0] = 3'd7; data_tab[0] = 16'h0001;
    addr_tab[1] = 3'd7; data_tab[1] = 16'h0002;
    req = 4'b0011;
    push_write(0, 3'd7, 16'h0001);
    push_write(1, 3'd7, 16'h0002);
    push_idle();
    run_cycles(3, 1'b1);
    check("rf7_final", 32'(rf[7]), 32'h0002);

    // Mid-cycle reset drops the in-flight write; arbitration restarts at 0.
    $display("[TB] mid-cycle reset");
    addr_tab[0] = 3'd1; data_tab[0] = 16'hC001;
    addr_tab[1] = 3'd2; data_tab[1] = 16'hC002;
    addr_tab[2] = 3'd3; data_tab[2] = 16'hC003;
    addr_tab[3] = 3'd4; data_tab[3] = 16'hC004;
    req = 4'b1111;
    push_write(2, 3'd3, 16'hC003);
    run_cycles(1, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mrst_gnt", 32'(gnt), 32'h0);
    check("mrst_wr_en", 32'(wr_en), 32'h0);
    check("mrst_wr_addr", 32'(wr_addr), 32'h0);
    check("mrst_wr_data", 32'(wr_data), 32'h0);
    check("mrst_busy", 32'(busy), 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    req = 4'b1111;
    push_write(0, 3'd1, 16'hC001);
    push_write(1, 3'd2, 16'hC002);
    push_write(2, 3'd3, 16'hC003);
    push_write(3, 3'd4, 16'hC004);
    push_idle();
    run_cycles(5, 1'b1);

    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
